feature_map_collector: RTL and testbench
========================================

FEATURE_MAP_COLLECTOR -- requirements
Module: feature_map_collector

Interface
REQ-001 SHALL have parameter O_WIDTH, default 16, the bit width of one channel value.
REQ-002 SHALL have parameter CHANNELS, default 5, the number of channels per input word.
REQ-003 SHALL have parameter MAP_SIZE, default 15, the side length of the square feature map (225 positions).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port input_data, input, CHANNELS*O_WIDTH, the layer output word; channel c occupies bits [c*O_WIDTH +: O_WIDTH].
REQ-007 SHALL have port valid, input, 1, qualifying input_data for one position per high cycle.
REQ-008 SHALL have port output_data, output, O_WIDTH, the single-channel readout value.
REQ-009 SHALL have port output_channel, output, 3, the channel index of output_data.
REQ-010 SHALL have port output_valid, output, 1, meaning output_data holds a readout value.
REQ-011 SHALL have port output_ready, input, 1, the consumer acceptance of the readout value.
REQ-012 SHALL have port frame_done, output, 1, a one-cycle pulse after the last readout transfer of a frame.
REQ-013 SHALL have port overflow, output, 1, a sticky flag for input words dropped during readout.
REQ-014 SHALL have port frame_count, output, 8, the number of completed frames, modulo 256.

Function
REQ-015 SHALL hold an internal buffer of MAP_SIZE*MAP_SIZE entries, each CHANNELS*O_WIDTH bits wide.
REQ-016 SHALL implement two states: CAPTURE and READOUT.
REQ-017 In CAPTURE, each cycle with valid=1 SHALL write input_data to buffer[wr_ptr] and increment wr_ptr.
REQ-018 In CAPTURE, the write with wr_ptr = MAP_SIZE*MAP_SIZE-1 SHALL clear wr_ptr to 0 and move the state to READOUT on the next cycle.
REQ-019 In CAPTURE, output_valid SHALL be 0.
REQ-020 In READOUT, output_valid SHALL be 1, output_data SHALL equal channel rd_ch of buffer[rd_pos], and output_channel SHALL equal rd_ch.
REQ-021 The first output_valid SHALL rise in the cycle immediately after the final capture write.
REQ-022 Readout order SHALL be position-major, then channel ascending: (pos 0, ch 0), (0, 1) ... (0, CHANNELS-1), (1, 0) ... and so on.
REQ-023 A transfer SHALL occur on a cycle with output_valid=1 and output_ready=1.
REQ-024 On each transfer, rd_ch SHALL increment; at CHANNELS-1 it SHALL wrap to 0 and rd_pos SHALL increment.
REQ-025 While output_valid=1 and output_ready=0, output_data and output_channel SHALL remain stable.
REQ-026 The transfer of (pos MAP_SIZE*MAP_SIZE-1, ch CHANNELS-1) SHALL do all of the following on the next cycle:
- return the state to CAPTURE;
- clear rd_pos and rd_ch;
- pulse frame_done for exactly one cycle;
- increment frame_count, wrapping from 255 to 0.
REQ-027 In READOUT, valid=1 SHALL NOT write the buffer and SHALL set overflow to 1; overflow SHALL stay 1 until reset.
REQ-028 In the cycle frame_done pulses, the state is CAPTURE, so valid=1 in that cycle SHALL be captured at position 0.
REQ-029 Buffer contents SHALL never be modified during READOUT.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL do all of the following:
- set the state to CAPTURE;
- clear wr_ptr, rd_pos and rd_ch;
- drive output_valid=0, frame_done=0, overflow=0 and frame_count=0;
- ignore valid.
REQ-031 Reset SHALL NOT be required to clear buffer contents.
REQ-032 Reset asserted mid-capture or mid-readout SHALL abandon the partial frame, and the next frame SHALL start at position 0.

Verification
REQ-033 Stream 225 words with channel c of position p = p*8+c, output_ready held at 1 -> output_valid rises the next cycle; 1125 values appear in REQ-022 order; frame_done pulses once; frame_count=1.
REQ-034 During readout, toggle output_ready randomly -> no value is lost or duplicated, and output_data is stable during every valid&&!ready cycle.
REQ-035 Drive valid=1 for 3 cycles during readout -> overflow=1 and the buffer is unchanged; overflow stays 1 after the frame completes, until reset.
REQ-036 Assert reset after 100 captured words, then stream a full frame -> the readout matches the new frame only, and frame_count=1.
REQ-037 Run 257 back-to-back frames with valid=1 in the frame_done cycle -> that word lands at position 0, and frame_count wraps to 1.
REQ-038 Drive valid with gaps (1 cycle in 3) -> capture counts only the valid cycles, and READOUT entry occurs after the 225th valid cycle.

Source files
------------

// File: rtl/feature_map_collector.sv
// ---------------------------------------------------------------------------
// feature_map_collector
//
// Collects one full square feature map (MAP_SIZE x MAP_SIZE positions, each a
// CHANNELS-wide word) from a layer output stream, then plays it back one
// channel value at a time over a valid/ready interface.
//
// The block alternates between two phases:
//   CAPTURE : every valid cycle stores input_data at the next position.
//   READOUT : the stored map is emitted position-major, channel-ascending.
//             Input words arriving here are dropped and flagged on overflow.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   input_data     in   CHANNELS*O_WIDTH; channel c at [c*O_WIDTH +: O_WIDTH]
//   valid          in   input_data qualifier, one position per high cycle
//   output_data    out  O_WIDTH readout value
//   output_channel out  3-bit channel index of output_data
//   output_valid   out  high for the whole READOUT phase
//   output_ready   in   consumer acceptance; transfer = valid && ready
//   frame_done     out  one-cycle pulse after the last transfer of a frame
//   overflow       out  sticky: an input word was dropped during READOUT
//   frame_count    out  completed frames, modulo 256
// ---------------------------------------------------------------------------
module feature_map_collector #(
    parameter int O_WIDTH  = 16,
    parameter int CHANNELS = 5,
    parameter int MAP_SIZE = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*O_WIDTH-1:0]  input_data,
    input  logic                         valid,
    output logic [O_WIDTH-1:0]           output_data,
    output logic [2:0]                   output_channel,
    output logic                         output_valid,
    input  logic                         output_ready,
    output logic                         frame_done,
    output logic                         overflow,
    output logic [7:0]                   frame_count
);

    localparam int DEPTH  = MAP_SIZE * MAP_SIZE;
    localparam int POS_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WORD_W = CHANNELS * O_WIDTH;

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

    typedef enum logic {
        CAPTURE = 1'b0,
        READOUT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            r_state;
    logic [POS_W-1:0]  r_wr_ptr;
    logic [POS_W-1:0]  r_rd_pos;
    logic [CH_W-1:0]   r_rd_ch;
    logic              r_out_valid;
    logic              r_frame_done;
    logic              r_overflow;
    logic [7:0]        r_frame_count;

    logic [WORD_W-1:0] r_buf [DEPTH];

    logic              w_capture_wr;
    logic              w_transfer;
    logic [WORD_W-1:0] w_rd_word;
    logic [O_WIDTH-1:0] w_rd_value;

    // Writes are only accepted while capturing; a dropped READOUT word must
    // never reach the buffer, so the frame being played back stays intact.
    assign w_capture_wr = !reset && (r_state == CAPTURE) && valid;
    assign w_transfer   = r_out_valid && output_ready;

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of
    // statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= CAPTURE;
            r_wr_ptr      <= '0;
            r_rd_pos      <= '0;
            r_rd_ch       <= '0;
            r_out_valid   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;

            case (r_state)
                CAPTURE: begin
                    if (valid) begin
                        if (r_wr_ptr == LAST_POS) begin
                            r_wr_ptr    <= '0;
                            r_state     <= READOUT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end

                READOUT: begin
                    if (valid) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_transfer) begin
                        if (r_rd_ch == LAST_CH) begin
                            r_rd_ch <= '0;
                            if (r_rd_pos == LAST_POS) begin
                                // Last value of the frame: go back to
                                // capture so the very next cycle can accept
                                // position 0 of the following frame.
                                r_rd_pos      <= '0;
                                r_state       <= CAPTURE;
                                r_out_valid   <= 1'b0;
                                r_frame_done  <= 1'b1;
                                r_frame_count <= r_frame_count + 1'b1;
                            end else begin
                                r_rd_pos <= r_rd_pos + 1'b1;
                            end
                        end else begin
                            r_rd_ch <= r_rd_ch + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= CAPTURE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Feature-map buffer
    // -----------------------------------------------------------------------
    // NOTE: the buffer has no reset branch; every entry is rewritten before
    // it is read, and leaving it out lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_capture_wr) begin
            r_buf[r_wr_ptr] <= input_data;
        end
    end

    // -----------------------------------------------------------------------
    // Readout channel select
    // -----------------------------------------------------------------------
    // The read address only moves on a transfer, so output_data holds steady
    // while the consumer stalls.
    assign w_rd_word = r_buf[r_rd_pos];

    // NOTE: w_rd_value gets a default before the loop so no path through
    // this block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rd_value = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_rd_ch == CH_W'(c)) begin
                w_rd_value = w_rd_word[c*O_WIDTH +: O_WIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign output_data    = w_rd_value;
    assign output_channel = 3'(r_rd_ch);
    assign output_valid   = r_out_valid;
    assign frame_done     = r_frame_done;
    assign overflow       = r_overflow;
    assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_feature_map_collector.sv
// ---------------------------------------------------------------------------
// tb_feature_map_collector
//
// Directed bench. The default-size instance covers single frames, stalls,
// overflow, mid-frame reset and gapped input. A 2x2, 2-channel instance runs
// 257 back-to-back frames so the frame counter wrap stays short.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_feature_map_collector;

    localparam int OW   = 16;
    localparam int CH   = 5;
    localparam int MS   = 15;
    localparam int NPOS = MS * MS;
    localparam int NVAL = NPOS * CH;

    logic              clk;
    logic              reset;
    logic [CH*OW-1:0]  input_data;
    logic              valid;
    logic [OW-1:0]     output_data;
    logic [2:0]        output_channel;
    logic              output_valid;
    logic              output_ready;
    logic              frame_done;
    logic              overflow;
    logic [7:0]        frame_count;

    logic [2*OW-1:0]   s_input_data;
    logic              s_valid;
    logic [OW-1:0]     s_output_data;
    logic [2:0]        s_output_channel;
    logic              s_output_valid;
    logic              s_output_ready;
    logic              s_frame_done;
    logic              s_overflow;
    logic [7:0]        s_frame_count;

    int n_checks = 0;
    int n_errors = 0;

    feature_map_collector #(.O_WIDTH(OW), .CHANNELS(CH), .MAP_SIZE(MS)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .input_data     (input_data),
        .valid          (valid),
        .output_data    (output_data),
        .output_channel (output_channel),
        .output_valid   (output_valid),
        .output_ready   (output_ready),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .frame_count    (frame_count)
    );

    feature_map_collector #(.O_WIDTH(OW), .CHANNELS(2), .MAP_SIZE(2)) u_small (
        .clk            (clk),
        .reset          (reset),
        .input_data     (s_input_data),
        .valid          (s_valid),
        .output_data    (s_output_data),
        .output_channel (s_output_channel),
        .output_valid   (s_output_valid),
        .output_ready   (s_output_ready),
        .frame_done     (s_frame_done),
        .overflow       (s_overflow),
        .frame_count    (s_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel c of position p carries base + p*8 + c.
    function automatic logic [CH*OW-1:0] mk_word(input int base, input int p);
        logic [CH*OW-1:0] w;
        for (int c = 0; c < CH; c++) begin
            w[c*OW +: OW] = OW'(base + p*8 + c);
        end
        return w;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        s_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Feed n words; with gap set, two idle cycles precede every valid cycle.
    task automatic capture(input int base, input int n, input bit gap);
        for (int p = 0; p < n; p++) begin
            if (gap) begin
                valid = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    check("cap_idle_ovalid", output_valid, 0);
                end
            end
            input_data = mk_word(base, p);
            valid      = 1'b1;
            if (p == NPOS - 1) check("pre_last_ovalid", output_valid, 0);
            tick();
        end
        valid = 1'b0;
    endtask

    // Drain one frame; rnd toggles output_ready, inject drives three input
    // words at the start of readout.
    task automatic read_frame(input int base, input bit rnd, input bit inject,
                              input logic [7:0] exp_fc);
        int idx = 0;
        int cyc = 0;
        bit took;
        while (idx < NVAL && cyc < 5000) begin
            output_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && cyc < 3) begin
                valid      = 1'b1;
                input_data = '1;
            end else begin
                valid = 1'b0;
            end
            check("rd_ovalid", output_valid, 1);
            check("rd_data", output_data, 32'(OW'(base + (idx / CH) * 8 + idx % CH)));
            check("rd_chan", output_channel, idx % CH);
            took = output_valid && output_ready;
            tick();
            cyc++;
            if (took) idx++;
        end
        valid        = 1'b0;
        output_ready = 1'b0;
        check("rd_count", idx, NVAL);
        check("done_pulse", frame_done, 1);
        check("ovalid_after", output_valid, 0);
        check("frame_count", frame_count, exp_fc);
        tick();
        check("done_single", frame_done, 0);
    endtask

    initial begin
        reset          = 1'b1;
        valid          = 1'b0;
        input_data     = '0;
        output_ready   = 1'b0;
        s_valid        = 1'b0;
        s_input_data   = '0;
        s_output_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_ovalid", output_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fcount", frame_count, 0);

        // Plain frame, consumer always ready.
        capture(32'h0000, NPOS, 1'b0);
        check("ovalid_rise", output_valid, 1);
        read_frame(32'h0000, 1'b0, 1'b0, 8'd1);
        check("no_overflow", overflow, 0);

        // Consumer stalls at random.
        capture(32'h1000, NPOS, 1'b0);
        check("ovalid_rise2", output_valid, 1);
        read_frame(32'h1000, 1'b1, 1'b0, 8'd2);

        // Words arriving during readout are dropped and flagged.
        capture(32'h2000, NPOS, 1'b0);
        read_frame(32'h2000, 1'b0, 1'b1, 8'd3);
        check("overflow_set", overflow, 1);
        repeat (3) tick();
        check("overflow_sticky", overflow, 1);
        do_reset();
        check("overflow_clr", overflow, 0);
        check("fcount_clr", frame_count, 0);

        // Reset in the middle of a capture abandons the partial frame.
        capture(32'h3000, 100, 1'b0);
        do_reset();
        check("midrst_ovalid", output_valid, 0);
        capture(32'h4000, NPOS, 1'b0);
        check("ovalid_rise3", output_valid, 1);
        read_frame(32'h4000, 1'b0, 1'b0, 8'd1);

        // Sparse input: one valid cycle in three.
        capture(32'h5000, NPOS, 1'b1);
        check("gap_ovalid_rise", output_valid, 1);
        read_frame(32'h5000, 1'b0, 1'b0, 8'd2);

        // 257 back-to-back frames on the small instance; the first word of
        // each new frame arrives in the frame_done cycle.
        do_reset();
        s_output_ready = 1'b1;
        for (int f = 0; f < 257; f++) begin
            for (int p = 0; p < 4; p++) begin
                s_input_data = {OW'(f*16 + p*2 + 1), OW'(f*16 + p*2)};
                s_valid      = 1'b1;
                if (p == 0 && f > 0) check("s_done_pulse", s_frame_done, 1);
                tick();
            end
            s_valid = 1'b0;
            check("s_ovalid_rise", s_output_valid, 1);
            for (int i = 0; i < 8; i++) begin
                check("s_data", s_output_data, 32'(OW'(f*16 + i)));
                tick();
            end
        end
        check("s_done_last", s_frame_done, 1);
        check("s_fcount_wrap", s_frame_count, 1);
        check("s_no_overflow", s_overflow, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
